spi_slave: RTL and testbench

Byte-oriented SPI slave that sits directly downstream of `spi_master` on the serial link. It consumes `sck`/`mosi`/`cs_n`, returns `miso`, and presents received bytes and accepts transmit bytes over simple valid/ready handshakes in the system `clk` domain. All SPI pins are oversampled: the block has no logic clocked by `sck`.

---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_sync_edge.sv | 47 ++++
 rtl/spi_slave.sv | 177 +++++++++++++++++
 tb/tb_spi_slave.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: link FSM states and default word width.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  localparam int unsigned SPI_DATA_W = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with registered rise/fall strobes.
// All stages reset to 0. On cs_n this means a select line already low at
// reset release is never seen as a falling edge.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  // Shift the async input through the chain and compare with the delayed copy.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

  // Synchroniser, delayed copy and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI slave, fully oversampled in the clk domain, with a one-entry
// transmit buffer and valid/ready byte interfaces.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid
);

  localparam int unsigned CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_lvl;
  logic sck_lvl_unused, cs_lvl_unused, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sck),
    .level (sck_lvl_unused),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (cs_n),
    .level (cs_lvl_unused),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (mosi),
    .level (mosi_lvl),
    .rise  (mosi_rise_unused),
    .fall  (mosi_fall_unused)
  );

  spi_state_e              state_q, state_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]       rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0]       tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]       rx_data_q, rx_data_d;
  logic                    rx_valid_q, rx_valid_d;
  logic                    tx_underrun_q, tx_underrun_d;
  logic [DATA_W-1:0]       tx_buf_q, tx_buf_d;
  logic                    tx_full_q, tx_full_d;
  logic                    word_done_q, word_done_d;
  logic                    mosi_s_q;
  logic                    load;
  logic [DATA_W-1:0]       rx_word;

  // Next-state, shifting, word load and transmit-buffer handshake.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    rx_shift_d    = rx_shift_q;
    tx_shift_d    = tx_shift_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    tx_buf_d      = tx_buf_q;
    tx_full_d     = tx_full_q;
    word_done_d   = word_done_q;
    load          = 1'b0;
    rx_word       = {rx_shift_q[DATA_W-2:0], mosi_s_q};

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d     = ACTIVE;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
          load        = 1'b1;
        end
      end
      ACTIVE: begin
        // Deselect wins over a coincident sck strobe; the partial word is dropped.
        if (cs_rise) begin
          state_d     = IDLE;
          bit_cnt_d   = '0;
          word_done_d = 1'b0;
        end else begin
          if (sck_rise) begin
            rx_shift_d = rx_word;
            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
              bit_cnt_d   = '0;
              rx_data_d   = rx_word;
              rx_valid_d  = 1'b1;
              word_done_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
          end
          if (sck_fall) begin
            if (word_done_q) begin
              load        = 1'b1;
              word_done_d = 1'b0;
            end else begin
              tx_shift_d = tx_shift_q << 1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // The load sees the buffer as it was at the start of the cycle, so a
    // same-cycle capture lands in the buffer for the following word.
    if (load) begin
      if (tx_full_q) begin
        tx_shift_d = tx_buf_q;
        tx_full_d  = 1'b0;
      end else begin
        tx_shift_d    = '0;
        tx_underrun_d = 1'b1;
      end
    end
    if (tx_valid && !tx_full_q) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end
  end

  // State, datapath registers, and a one-cycle mosi delay that lines the
  // sampled bit up with the registered sck rise strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      rx_shift_q    <= '0;
      tx_shift_q    <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      tx_buf_q      <= '0;
      tx_full_q     <= 1'b0;
      word_done_q   <= 1'b0;
      mosi_s_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      rx_shift_q    <= rx_shift_d;
      tx_shift_q    <= tx_shift_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      word_done_q   <= word_done_d;
      mosi_s_q      <= mosi_lvl;
    end
  end

  assign miso        = (state_q == ACTIVE) ? tx_shift_q[DATA_W-1] : 1'b0;
  assign tx_ready    = ~tx_full_q;
  assign tx_underrun = tx_underrun_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Scenario bench for spi_slave: a mode-0 master at clk/8 plus an rx scoreboard.
module tb_spi_slave;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SYNC   = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sck, cs_n, mosi, miso;
  logic [DATA_W-1:0] tx_data, rx_data;
  logic              tx_valid, tx_ready, tx_underrun, rx_valid;

  int n_cmp  = 0;
  int n_err  = 0;
  int rv_cnt = 0;
  int ur_cnt = 0;
  logic [DATA_W-1:0] rx_exp_q[$];

  always #5 clk = ~clk;

  spi_slave #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sck         (sck),
    .cs_n        (cs_n),
    .mosi        (mosi),
    .miso        (miso),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_underrun (tx_underrun),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid)
  );

  // Scoreboard: every rx_valid pops the oldest expected word.
  always @(negedge clk) begin
    if (tx_underrun === 1'b1) ur_cnt++;
    if (rx_valid === 1'b1) begin
      logic [DATA_W-1:0] exp;
      rv_cnt++;
      n_cmp++;
      if (rx_exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rx_unexpected: rx_valid with rx_data=%h, no word expected", rx_data);
      end else begin
        exp = rx_exp_q.pop_front();
        if (rx_data !== exp) begin
          n_err++;
          $display("FAIL rx_data: got %h required %h", rx_data, exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  task automatic push_tx(input logic [DATA_W-1:0] d);
    int w;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    w = 0;
    while (tx_ready !== 1'b1 && w < 400) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (tx_ready !== 1'b1) begin
      n_err++;
      $display("FAIL tx_ready_wait: tx_ready=%b required 1 within 400 cycles", tx_ready);
    end
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Master side: mosi/sck change on clk negedges, miso sampled at sck rise.
  task automatic xfer(input logic [DATA_W-1:0] mo, input int nbits, output logic [DATA_W-1:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[DATA_W-1-i];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      mi  = {mi[DATA_W-2:0], miso};
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic frame_start();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp += 5;
    if (miso !== 1'b0)        begin n_err++; $display("FAIL reset_miso: got %b required 0", miso); end
    if (rx_data !== 8'h00)    begin n_err++; $display("FAIL reset_rx_data: got %h required 00", rx_data); end
    if (rx_valid !== 1'b0)    begin n_err++; $display("FAIL reset_rx_valid: got %b required 0", rx_valid); end
    if (tx_ready !== 1'b1)    begin n_err++; $display("FAIL reset_tx_ready: got %b required 1", tx_ready); end
    if (tx_underrun !== 1'b0) begin n_err++; $display("FAIL reset_tx_underrun: got %b required 0", tx_underrun); end
  endtask

  task automatic test_single_byte();
    logic [DATA_W-1:0] mi;
    int rv0, ur0;
    push_tx(8'hA5);
    n_cmp++;
    if (tx_ready !== 1'b0) begin n_err++; $display("FAIL single_preload_ready: got %b required 0", tx_ready); end
    rv0 = rv_cnt; ur0 = ur_cnt;
    frame_start();
    n_cmp++;
    if (tx_ready !== 1'b1) begin n_err++; $display("FAIL single_ready_after_load: got %b required 1", tx_ready); end
    rx_exp_q.push_back(8'h3C);
    xfer(8'h3C, 8, mi);
    frame_end();
    n_cmp += 5;
    if (mi !== 8'hA5)         begin n_err++; $display("FAIL single_miso: got %h required a5", mi); end
    if (rv_cnt - rv0 != 1)    begin n_err++; $display("FAIL single_rx_pulses: got %0d required 1", rv_cnt - rv0); end
    if (ur_cnt - ur0 != 1)    begin n_err++; $display("FAIL single_underruns: got %0d required 1", ur_cnt - ur0); end
    if (rx_exp_q.size() != 0) begin n_err++; $display("FAIL single_rx_pending: %0d words outstanding, required 0", rx_exp_q.size()); end
    if (miso !== 1'b0)        begin n_err++; $display("FAIL single_miso_idle: got %b required 0", miso); end
    rx_exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] mo [3];
    logic [DATA_W-1:0] me [3];
    logic [DATA_W-1:0] mi [3];
    int rv0, ur0;
    mo = '{8'hDE, 8'hAD, 8'hBE};
    me = '{8'h11, 8'h22, 8'h33};
    push_tx(8'h11);
    rv0 = rv_cnt; ur0 = ur_cnt;
    frame_start();
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          rx_exp_q.push_back(mo[k]);
          xfer(mo[k], 8, mi[k]);
        end
      end
      begin
        push_tx(8'h22);
        push_tx(8'h33);
      end
    join
    frame_end();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (mi[k] !== me[k]) begin n_err++; $display("FAIL b2b_miso[%0d]: got %h required %h", k, mi[k], me[k]); end
    end
    n_cmp += 3;
    if (rv_cnt - rv0 != 3)    begin n_err++; $display("FAIL b2b_rx_pulses: got %0d required 3", rv_cnt - rv0); end
    if (ur_cnt - ur0 != 1)    begin n_err++; $display("FAIL b2b_underruns: got %0d required 1", ur_cnt - ur0); end
    if (rx_exp_q.size() != 0) begin n_err++; $display("FAIL b2b_rx_pending: %0d words outstanding, required 0", rx_exp_q.size()); end
    rx_exp_q.delete();
  endtask

  task automatic test_underrun();
    logic [DATA_W-1:0] mi;
    int rv0, ur0;
    n_cmp++;
    if (tx_ready !== 1'b1) begin n_err++; $display("FAIL underrun_empty: tx_ready=%b required 1", tx_ready); end
    rv0 = rv_cnt; ur0 = ur_cnt;
    frame_start();
    rx_exp_q.push_back(8'h5A);
    xfer(8'h5A, 8, mi);
    frame_end();
    n_cmp += 4;
    if (mi !== 8'h00)         begin n_err++; $display("FAIL underrun_miso: got %h required 00", mi); end
    if (ur_cnt - ur0 != 2)    begin n_err++; $display("FAIL underrun_pulses: got %0d required 2", ur_cnt - ur0); end
    if (rv_cnt - rv0 != 1)    begin n_err++; $display("FAIL underrun_rx_pulses: got %0d required 1", rv_cnt - rv0); end
    if (rx_exp_q.size() != 0) begin n_err++; $display("FAIL underrun_rx_pending: %0d outstanding, required 0", rx_exp_q.size()); end
    rx_exp_q.delete();
  endtask

  task automatic test_abort();
    logic [DATA_W-1:0] mi;
    int rv0;
    push_tx(8'hF7);
    rv0 = rv_cnt;
    frame_start();
    push_tx(8'h0F);
    xfer(8'hFF, 5, mi);
    frame_end();
    n_cmp += 4;
    if (mi !== 8'h1E)      begin n_err++; $display("FAIL abort_partial_miso: got %h required 1e", mi); end
    if (rv_cnt != rv0)     begin n_err++; $display("FAIL abort_rx_pulses: got %0d required 0", rv_cnt - rv0); end
    if (tx_ready !== 1'b0) begin n_err++; $display("FAIL abort_buf_kept: tx_ready=%b required 0", tx_ready); end
    if (miso !== 1'b0)     begin n_err++; $display("FAIL abort_miso_idle: got %b required 0", miso); end
    frame_start();
    rx_exp_q.push_back(8'h81);
    xfer(8'h81, 8, mi);
    frame_end();
    n_cmp += 3;
    if (mi !== 8'h0F)         begin n_err++; $display("FAIL abort_next_miso: got %h required 0f", mi); end
    if (rv_cnt - rv0 != 1)    begin n_err++; $display("FAIL abort_next_rx_pulses: got %0d required 1", rv_cnt - rv0); end
    if (rx_exp_q.size() != 0) begin n_err++; $display("FAIL abort_rx_pending: %0d outstanding, required 0", rx_exp_q.size()); end
    rx_exp_q.delete();
  endtask

  // tx_valid rises so that the capture lands on the cs_n-fall word load.
  task automatic test_handshake_corner();
    logic [DATA_W-1:0] mi0, mi1;
    int rv0, ur0;
    rv0 = rv_cnt; ur0 = ur_cnt;
    @(negedge clk);
    cs_n = 1'b0;
    repeat (SYNC + 1) @(negedge clk);
    n_cmp++;
    if (tx_ready !== 1'b1) begin n_err++; $display("FAIL corner_ready_before: got %b required 1", tx_ready); end
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    n_cmp++;
    if (tx_ready !== 1'b0) begin n_err++; $display("FAIL corner_captured: tx_ready=%b required 0", tx_ready); end
    repeat (4) @(negedge clk);
    rx_exp_q.push_back(8'h5B);
    xfer(8'h5B, 8, mi0);
    rx_exp_q.push_back(8'hC4);
    xfer(8'hC4, 8, mi1);
    frame_end();
    n_cmp += 5;
    if (mi0 !== 8'h00)        begin n_err++; $display("FAIL corner_miso0: got %h required 00", mi0); end
    if (mi1 !== 8'hC3)        begin n_err++; $display("FAIL corner_miso1: got %h required c3", mi1); end
    if (ur_cnt - ur0 != 2)    begin n_err++; $display("FAIL corner_underruns: got %0d required 2", ur_cnt - ur0); end
    if (rv_cnt - rv0 != 2)    begin n_err++; $display("FAIL corner_rx_pulses: got %0d required 2", rv_cnt - rv0); end
    if (rx_exp_q.size() != 0) begin n_err++; $display("FAIL corner_rx_pending: %0d outstanding, required 0", rx_exp_q.size()); end
    rx_exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [DATA_W-1:0] mi;
    int rv0;
    push_tx(8'h12);
    frame_start();
    push_tx(8'h34);
    xfer(8'hFF, 3, mi);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp += 5;
    if (miso !== 1'b0)        begin n_err++; $display("FAIL rstmid_miso: got %b required 0", miso); end
    if (rx_data !== 8'h00)    begin n_err++; $display("FAIL rstmid_rx_data: got %h required 00", rx_data); end
    if (rx_valid !== 1'b0)    begin n_err++; $display("FAIL rstmid_rx_valid: got %b required 0", rx_valid); end
    if (tx_ready !== 1'b1)    begin n_err++; $display("FAIL rstmid_tx_ready: got %b required 1", tx_ready); end
    if (tx_underrun !== 1'b0) begin n_err++; $display("FAIL rstmid_tx_underrun: got %b required 0", tx_underrun); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rv0 = rv_cnt;
    xfer(8'hFF, 8, mi);
    xfer(8'h00, 5, mi);
    repeat (8) @(negedge clk);
    n_cmp++;
    if (rv_cnt != rv0) begin n_err++; $display("FAIL rstmid_ignored_frame: got %0d rx pulses required 0", rv_cnt - rv0); end
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    frame_start();
    rx_exp_q.push_back(8'h42);
    xfer(8'h42, 8, mi);
    frame_end();
    n_cmp += 2;
    if (rv_cnt - rv0 != 1)    begin n_err++; $display("FAIL rstmid_new_frame_pulses: got %0d required 1", rv_cnt - rv0); end
    if (rx_exp_q.size() != 0) begin n_err++; $display("FAIL rstmid_rx_pending: %0d outstanding, required 0", rx_exp_q.size()); end
    rx_exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_handshake_corner();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
